// File: rtl/dk_pkg.sv
// Shared types and screen/motion constants for the Donkey Kong sprite controller.
package dk_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int DK_W     = 64;
  localparam int DK_H     = 32;

  localparam int X_MIN_DEF        = 16;
  localparam int X_MAX_DEF        = 560;
  localparam int Y_POS_DEF        = 48;
  localparam int STEP_DEF         = 2;
  localparam int ANIM_FRAMES_DEF  = 8;
  localparam int STAND_FRAMES_DEF = 60;
  localparam int THROW_FRAMES_DEF = 30;
  localparam int VBLANK_LINE_DEF  = 480;

  typedef enum logic [1:0] {
    WALK,
    STAND,
    THROW
  } dk_state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// One-cycle frame tick, registered one clock after the vblank-start pixel is seen.
module frame_tick_gen #(
  parameter int VBLANK_LINE = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hcount_i,
  input  logic [9:0] vcount_i,
  output logic       tick_o
);

  localparam logic [9:0] VBLANK_W = 10'(VBLANK_LINE);

  logic tick_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_q <= 1'b0;
    else     tick_q <= (hcount_i == 10'd0) && (vcount_i == VBLANK_W);
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/dk_motion_ctrl.sv
// Donkey Kong pacing controller: walk between bounds, stand, throw a barrel, walk back.
module dk_motion_ctrl
  import dk_pkg::*;
#(
  parameter int X_MIN        = X_MIN_DEF,
  parameter int X_MAX        = X_MAX_DEF,
  parameter int Y_POS        = Y_POS_DEF,
  parameter int STEP         = STEP_DEF,
  parameter int ANIM_FRAMES  = ANIM_FRAMES_DEF,
  parameter int STAND_FRAMES = STAND_FRAMES_DEF,
  parameter int THROW_FRAMES = THROW_FRAMES_DEF,
  parameter int VBLANK_LINE  = VBLANK_LINE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       throw_ack,
  output logic [9:0] curr_h,
  output logic [9:0] curr_v,
  output logic       sprite_selec,
  output logic       throw_req,
  output logic       dir_right
);

  localparam logic [10:0] X_MIN_W  = 11'(X_MIN);
  localparam logic [10:0] X_MAX_W  = 11'(X_MAX);
  localparam logic [10:0] STEP_W   = 11'(STEP);
  localparam logic [7:0]  ANIM_END  = 8'(ANIM_FRAMES - 1);
  localparam logic [7:0]  STAND_END = 8'(STAND_FRAMES - 1);
  localparam logic [7:0]  THROW_END = 8'(THROW_FRAMES - 1);

  dk_state_t  state_q;
  logic [9:0] h_q;
  logic       sel_q, req_q, dir_q, ack_seen_q;
  logic [7:0] anim_cnt_q, stand_cnt_q, throw_cnt_q;
  logic       tick;

  logic [10:0] h_ext;
  logic [9:0]  walk_h_d;
  logic        walk_hit_d;

  frame_tick_gen #(
    .VBLANK_LINE(VBLANK_LINE)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .hcount_i (hcount),
    .vcount_i (vcount),
    .tick_o   (tick)
  );

  // Bound test is widened so a step left of a small X can never wrap.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    h_ext      = {1'b0, h_q};
    walk_h_d   = h_q;
    walk_hit_d = 1'b0;
    if (dir_q) begin
      if (h_ext + STEP_W >= X_MAX_W) begin
        walk_hit_d = 1'b1;
        walk_h_d   = X_MAX_W[9:0];
      end else begin
        walk_h_d = 10'(h_ext + STEP_W);
      end
    end else begin
      if (h_ext <= X_MIN_W + STEP_W) begin
        walk_hit_d = 1'b1;
        walk_h_d   = X_MIN_W[9:0];
      end else begin
        walk_h_d = 10'(h_ext - STEP_W);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WALK;
      h_q         <= X_MIN_W[9:0];
      sel_q       <= 1'b0;
      req_q       <= 1'b0;
      dir_q       <= 1'b1;
      ack_seen_q  <= 1'b0;
      anim_cnt_q  <= '0;
      stand_cnt_q <= '0;
      throw_cnt_q <= '0;
    end else if (enable) begin
      // NOTE: non-blocking throughout, so an ack and a tick in the same cycle both see pre-edge state.
      if (req_q && throw_ack) begin
        req_q      <= 1'b0;
        ack_seen_q <= 1'b1;
      end
      if (tick) begin
        unique case (state_q)
          WALK: begin
            h_q <= walk_h_d;
            if (walk_hit_d) begin
              state_q     <= STAND;
              stand_cnt_q <= '0;
              sel_q       <= 1'b0;
            end else if (anim_cnt_q == ANIM_END) begin
              anim_cnt_q <= '0;
              sel_q      <= ~sel_q;
            end else begin
              anim_cnt_q <= anim_cnt_q + 8'd1;
            end
          end
          STAND: begin
            if (stand_cnt_q == STAND_END) begin
              state_q     <= THROW;
              req_q       <= 1'b1;
              sel_q       <= 1'b1;
              throw_cnt_q <= '0;
              ack_seen_q  <= 1'b0;
            end else begin
              stand_cnt_q <= stand_cnt_q + 8'd1;
            end
          end
          THROW: begin
            if (ack_seen_q) begin
              if (throw_cnt_q == THROW_END) begin
                state_q    <= WALK;
                dir_q      <= ~dir_q;
                anim_cnt_q <= '0;
                ack_seen_q <= 1'b0;
              end else begin
                throw_cnt_q <= throw_cnt_q + 8'd1;
              end
            end
          end
          default: state_q <= WALK;
        endcase
      end
    end
  end

  assign curr_h       = h_q;
  assign curr_v       = 10'(Y_POS);
  assign sprite_selec = sel_q;
  assign throw_req    = req_q;
  assign dir_right    = dir_q;

endmodule

// File: tb/tb_dk_motion_ctrl.sv
// Self-checking bench for dk_motion_ctrl: vector table, hand sequences, random run against a frame-level model.
module tb_dk_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst, enable, throw_ack;
  logic [9:0] hcount, vcount;
  logic [9:0] curr_h, curr_v;
  logic       sprite_selec, throw_req, dir_right;

  dk_motion_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .hcount       (hcount),
    .vcount       (vcount),
    .throw_ack    (throw_ack),
    .curr_h       (curr_h),
    .curr_v       (curr_v),
    .sprite_selec (sprite_selec),
    .throw_req    (throw_req),
    .dir_right    (dir_right)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame-level behavioural model: one call per enabled frame tick.
  localparam int P_WALK = 0, P_STAND = 1, P_THROW = 2;
  int m_h, m_dir, m_sel, m_req, m_phase, m_anim, m_cnt, m_acked;

  task automatic m_reset();
    m_h = 16; m_dir = 1; m_sel = 0; m_req = 0;
    m_phase = P_WALK; m_anim = 0; m_cnt = 0; m_acked = 0;
  endtask

  task automatic m_ack(input bit en);
    if (en && m_req == 1) begin
      m_req   = 0;
      m_acked = 1;
    end
  endtask

  task automatic m_tick(input bit en);
    if (!en) return;
    case (m_phase)
      P_WALK: begin
        if (m_dir == 1 && m_h + 2 >= 560) begin
          m_h = 560; m_phase = P_STAND; m_cnt = 0; m_sel = 0;
        end else if (m_dir == 0 && m_h - 2 <= 16) begin
          m_h = 16; m_phase = P_STAND; m_cnt = 0; m_sel = 0;
        end else begin
          m_h = (m_dir == 1) ? m_h + 2 : m_h - 2;
          m_anim++;
          if (m_anim == 8) begin
            m_anim = 0;
            m_sel  = 1 - m_sel;
          end
        end
      end
      P_STAND: begin
        m_cnt++;
        if (m_cnt == 60) begin
          m_phase = P_THROW; m_req = 1; m_sel = 1; m_cnt = 0; m_acked = 0;
        end
      end
      default: begin
        if (m_acked == 1) begin
          m_cnt++;
          if (m_cnt == 30) begin
            m_phase = P_WALK; m_dir = 1 - m_dir; m_anim = 0; m_cnt = 0; m_acked = 0;
          end
        end
      end
    endcase
  endtask

  // One short frame: trigger pixel in cycle 0, tick in cycle 1, optional ack pulse in cycle ack_pos.
  task automatic frame(input bit en, input int ack_pos);
    bit ack_ok;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      enable    = en;
      throw_ack = (c == ack_pos);
      case (c)
        0:       begin hcount = 10'd0;   vcount = 10'd480; end
        1:       begin hcount = 10'd1;   vcount = 10'd480; end
        2:       begin hcount = 10'd0;   vcount = 10'd479; end
        default: begin hcount = 10'd320; vcount = 10'd200; end
      endcase
    end
    @(negedge clk);
    throw_ack = 1'b0;
    hcount    = 10'd100;
    vcount    = 10'd100;
    if (ack_pos == 0) begin
      m_ack(en);
      m_tick(en);
    end else if (ack_pos == 1) begin
      ack_ok = en && (m_req == 1);
      m_tick(en);
      if (ack_ok) m_ack(en);
    end else begin
      m_tick(en);
      if (ack_pos >= 2) m_ack(en);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".h"},   int'(curr_h),       m_h);
    check({tag, ".v"},   int'(curr_v),       48);
    check({tag, ".sel"}, int'(sprite_selec), m_sel);
    check({tag, ".req"}, int'(throw_req),    m_req);
    check({tag, ".dir"}, int'(dir_right),    m_dir);
  endtask

  typedef struct {
    bit en;
    bit ack;
    int reps;
    int h;
    bit sel;
    bit dir;
    bit req;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 10, 18, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1,  6, 30, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 10, 30, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0,  1, 32, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0,  7, 46, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0,  1, 48, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; enable = 1'b0; throw_ack = 1'b0;
    hcount = 10'd200; vcount = 10'd300;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_reset();
    @(negedge clk);
    check("reset.h",   int'(curr_h),       16);
    check("reset.v",   int'(curr_v),       48);
    check("reset.sel", int'(sprite_selec), 0);
    check("reset.req", int'(throw_req),    0);
    check("reset.dir", int'(dir_right),    1);

    // First tick: position moves exactly two clocks after the trigger pixel.
    enable = 1'b1; hcount = 10'd0; vcount = 10'd480;
    @(negedge clk);
    hcount = 10'd1;
    check("first.pre_h", int'(curr_h), 16);
    @(negedge clk);
    hcount = 10'd100; vcount = 10'd100;
    check("first.post_h", int'(curr_h), 18);
    m_tick(1'b1);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) frame(vecs[i].en, vecs[i].ack ? 2 : -1);
      check($sformatf("vec%0d.h", i),   int'(curr_h),       vecs[i].h);
      check($sformatf("vec%0d.sel", i), int'(sprite_selec), int'(vecs[i].sel));
      check($sformatf("vec%0d.dir", i), int'(dir_right),    int'(vecs[i].dir));
      check($sformatf("vec%0d.req", i), int'(throw_req),    int'(vecs[i].req));
    end

    for (int i = 0; i < 400 && m_phase == P_WALK; i++) frame(1'b1, -1);
    check("rbound.h",   int'(curr_h),       560);
    check("rbound.sel", int'(sprite_selec), 0);
    check("rbound.req", int'(throw_req),    0);

    repeat (59) frame(1'b1, -1);
    check("stand59.req", int'(throw_req),    0);
    check("stand59.sel", int'(sprite_selec), 0);
    frame(1'b1, -1);
    check("stand60.req", int'(throw_req),    1);
    check("stand60.sel", int'(sprite_selec), 1);

    repeat (200) frame(1'b1, -1);
    check("noack.req", int'(throw_req), 1);
    check("noack.h",   int'(curr_h),    560);

    // Ack pulse coincides with a tick: request drops next clock, that tick is not counted.
    @(negedge clk);
    enable = 1'b1; hcount = 10'd0; vcount = 10'd480;
    @(negedge clk);
    hcount = 10'd1; throw_ack = 1'b1;
    @(negedge clk);
    throw_ack = 1'b0; hcount = 10'd100; vcount = 10'd100;
    check("ack.req_drop", int'(throw_req), 0);
    m_tick(1'b1);
    m_ack(1'b1);
    repeat (2) @(negedge clk);

    repeat (29) frame(1'b1, -1);
    check("throw29.dir", int'(dir_right), 1);
    frame(1'b1, -1);
    check("throw30.dir", int'(dir_right), 0);
    check("throw30.h",   int'(curr_h),    560);
    frame(1'b1, -1);
    check("walkback.h",  int'(curr_h),    558);

    for (int i = 0; i < 400 && m_phase == P_WALK; i++) frame(1'b1, -1);
    check("lbound.h",   int'(curr_h),       16);
    check("lbound.sel", int'(sprite_selec), 0);
    check("lbound.dir", int'(dir_right),    0);

    for (int i = 0; i < 1500; i++) begin
      bit en;
      int ap;
      en = ($urandom_range(0, 4) != 0);
      ap = (en && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      frame(en, ap);
      compare_all($sformatf("rnd%0d", i));
    end

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst.h",   int'(curr_h),       16);
    check("midrst.sel", int'(sprite_selec), 0);
    check("midrst.req", int'(throw_req),    0);
    check("midrst.dir", int'(dir_right),    1);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    frame(1'b1, -1);
    check("postrst.h", int'(curr_h), 18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dk_motion_ctrl.md
Name: dk_motion_ctrl

Overview:
- Sequential controller directly upstream of the Donkey Kong sprite-position stage.
- Produces the sprite's top-left origin (curr_h, curr_v) and the stand/side sprite select each frame.
- Sequence: pace between horizontal bounds, stand, throw a barrel via handshake to the barrel spawner, then walk back.
- All state updates happen once per frame, at vertical-blank start, so the drawn sprite never tears.

Parameters:
- X_MIN, 16: leftmost legal curr_h.
- X_MAX, 560: rightmost legal curr_h (sprite 64 wide, so 560+64 ≤ 640-16).
- Y_POS, 48: fixed curr_v.
- STEP, 2: pixels moved per frame while walking.
- ANIM_FRAMES, 8: frames between sprite toggles while walking.
- STAND_FRAMES, 60: frames held in STAND.
- THROW_FRAMES, 30: minimum frames in THROW after ack.
- VBLANK_LINE, 480: vcount value marking frame end.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  game running; low freezes all state
- hcount  in  10  current pixel column from VGA timing
- vcount  in  10  current line from VGA timing
- throw_ack  in  1  barrel spawner accepted the throw
- curr_h  out  10  sprite origin X
- curr_v  out  10  sprite origin Y
- sprite_selec  out  1  0 = stand sprite, 1 = side sprite
- throw_req  out  1  barrel throw request, level
- dir_right  out  1  current walk direction, 1 = right

Behaviour:
- Clock and reset: one clock domain (clk). rst is asynchronous and active-high; all flops clear immediately on assertion.
- Reset values:
  - curr_h = X_MIN, curr_v = Y_POS
  - sprite_selec = 0, throw_req = 0, dir_right = 1
  - state = WALK, all counters = 0
- Frame tick:
  - tick is a registered one-cycle pulse, asserted the cycle after hcount==0 && vcount==VBLANK_LINE is sampled.
  - All position, state and counter updates occur only on a cycle with tick=1 && enable=1.
  - Exception: the throw_req/throw_ack handshake.
  - Outputs change exactly 1 clk after the tick, i.e. 2 clk after the trigger pixel.
- enable low: ticks are ignored and all outputs hold. A throw_req already asserted stays asserted.
- State WALK:
  - Each tick, curr_h moves ±STEP according to dir_right.
  - Clamp: if curr_h+STEP ≥ X_MAX (right) or curr_h−STEP ≤ X_MIN (left), curr_h takes the bound value and the next state is STAND.
  - Underflow is impossible; the comparison is done in 11 bits.
  - anim_cnt increments each tick; at ANIM_FRAMES−1 it wraps to 0 and sprite_selec toggles.
- State STAND:
  - sprite_selec = 0 and curr_h holds.
  - stand_cnt counts ticks; at STAND_FRAMES−1 the state goes to THROW and throw_req is set to 1.
- State THROW:
  - sprite_selec = 1.
  - throw_req stays high until the first clk with throw_ack=1. It clears on the next edge; no tick is needed.
  - throw_cnt counts ticks only after the ack has been seen.
  - At THROW_FRAMES−1, after the ack: dir_right inverts, anim_cnt clears, and the state goes to WALK.
  - If no ack arrives, the FSM stays in THROW indefinitely.
- Ack edge cases: throw_ack when throw_req=0 is ignored. Ack and tick in the same cycle: the ack is registered, and that tick does not yet count toward throw_cnt.
- Counters clear on every state entry.
- curr_v is constant at Y_POS (vertical motion is reserved).
- Reset mid-operation: immediate return to reset values, including dropping throw_req.

Decomposition:
- Shared package dk_pkg:
  - state enum dk_state_t {WALK, STAND, THROW}
  - screen constants H_ACTIVE=640, V_ACTIVE=480, DK_W=64, DK_H=32
  - the default bound values
- Sub-module frame_tick_gen: hcount/vcount compare plus output register, emitting the one-cycle tick. The parent holds the FSM, position and counters.

Test Plan:
- Reset/first frame: assert rst mid-frame, release → curr_h=16, curr_v=48, sprite_selec=0, throw_req=0, dir_right=1. First tick → curr_h=18, 2 clk after hcount=0/vcount=480.
- Right bound clamp: preload curr_h=558, walking right → next tick curr_h=560, state STAND, sprite_selec=0. After 60 ticks → throw_req=1, sprite_selec=1.
- Handshake: hold throw_ack=0 for 200 ticks → throw_req stays 1 and curr_h=560. Pulse throw_ack 1 clk → throw_req=0 next clk. 30 ticks later → dir_right=0 and next tick curr_h=558.
- Animation: walking for 16 ticks → sprite_selec toggles exactly at ticks 8 and 16. Spurious throw_ack in WALK → no effect.
- Enable freeze: deassert enable for 10 frames in WALK → curr_h, sprite_selec and counters unchanged. Re-enable → motion resumes from the held value.
- Left bound: walking left from curr_h=17 → clamps to 16, STAND entered, no wrap to 1023.
